// File: rtl/seq_frame_tx_if.sv
// Handshake and serial-output bundle for seq_frame_tx.
// The master drives payload words in; the slave returns ready and the serial frame stream.
interface seq_frame_tx_if #(
    parameter int unsigned DATA_W = 8
);
    logic              din_valid;
    logic [DATA_W-1:0] din;
    logic              din_ready;
    logic              dout;
    logic              dout_en;
    logic              sof;
    logic              busy;

    modport master (
        output din_valid, din,
        input  din_ready, dout, dout_en, sof, busy
    );

    modport slave (
        input  din_valid, din,
        output din_ready, dout, dout_en, sof, busy
    );
endinterface

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sync pattern, MSB-first payload and optional even parity,
// with back-to-back frames when a new word is offered on the last bit of the current one.
module seq_frame_tx #(
    parameter int unsigned        DATA_W    = 8,
    parameter int unsigned        SYNC_W    = 4,
    parameter logic [SYNC_W-1:0]  SYNC_PAT  = SYNC_W'(4'b1011),
    parameter int unsigned        PARITY_EN = 1,
    parameter logic               IDLE_BIT  = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    seq_frame_tx_if.slave bus
);
    localparam int unsigned FRAME_W = SYNC_W + DATA_W + PARITY_EN;
    localparam int unsigned MAX_W   = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int unsigned CNT_W   = (MAX_W > 1) ? $clog2(MAX_W) : 1;

    typedef enum logic [1:0] {IDLE, SYNC, DATA, PARITY} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [FRAME_W-1:0] shreg;
    logic [FRAME_W-1:0] frame_c;
    logic               dout;
    logic               dout_en;
    logic               sof;
    logic               last_bit;
    logic               accept;

    // Final bit of a frame: the parity cycle, or the last payload bit when parity is off.
    assign last_bit = (state == PARITY) ||
                      ((state == DATA) && (cnt == CNT_W'(DATA_W - 1)) && (PARITY_EN == 0));

    assign bus.din_ready = rst & ((state == IDLE) | last_bit);
    assign accept        = bus.din_valid & bus.din_ready;

    assign bus.dout    = dout;
    assign bus.dout_en = dout_en;
    assign bus.sof     = sof;
    assign bus.busy    = dout_en;

    // Whole frame image for the word being accepted, MSB transmitted first.
    always_comb begin
        frame_c                          = '0;
        frame_c[FRAME_W-1 -: SYNC_W]     = SYNC_PAT;
        frame_c[FRAME_W-1-SYNC_W -: DATA_W] = bus.din;
        if (PARITY_EN != 0) begin
            frame_c[0] = ^bus.din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            shreg   <= '0;
            dout    <= IDLE_BIT;
            dout_en <= 1'b0;
            sof     <= 1'b0;
        end else begin
            sof <= 1'b0;
            if (accept) begin
                state   <= SYNC;
                cnt     <= '0;
                shreg   <= frame_c << 1;
                dout    <= frame_c[FRAME_W-1];
                dout_en <= 1'b1;
                sof     <= 1'b1;
            end else if (last_bit) begin
                state   <= IDLE;
                cnt     <= '0;
                shreg   <= '0;
                dout    <= IDLE_BIT;
                dout_en <= 1'b0;
            end else if (state != IDLE) begin
                dout  <= shreg[FRAME_W-1];
                shreg <= shreg << 1;
                cnt   <= cnt + CNT_W'(1);
                case (state)
                    SYNC: begin
                        if (cnt == CNT_W'(SYNC_W - 1)) begin
                            state <= DATA;
                            cnt   <= '0;
                        end
                    end
                    DATA: begin
                        // Only reached with parity enabled; otherwise last_bit ends the frame.
                        if (cnt == CNT_W'(DATA_W - 1)) begin
                            state <= PARITY;
                            cnt   <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_seq_frame_tx.sv
// Bench for seq_frame_tx: parity and no-parity builds driven in parallel, checked
// cycle by cycle against a bit-queue model plus fixed expected frame images.
module tb_seq_frame_tx;
    typedef struct {
        logic b;
        logic s;
    } fbit_t;

    logic       clk;
    logic       rst;
    logic       valid;
    logic [7:0] din;

    int unsigned n_assert;
    int unsigned n_fail;

    fbit_t qp[$];
    fbit_t qn[$];

    logic        cap_on;
    logic [63:0] cap_p;
    logic [63:0] cap_n;
    int unsigned cap_p_n;
    int unsigned cap_n_n;

    seq_frame_tx_if #(.DATA_W(8)) bus_p ();
    seq_frame_tx_if #(.DATA_W(8)) bus_n ();

    assign bus_p.din_valid = valid;
    assign bus_p.din       = din;
    assign bus_n.din_valid = valid;
    assign bus_n.din       = din;

    seq_frame_tx #(.DATA_W(8), .SYNC_W(4), .SYNC_PAT(4'b1011), .PARITY_EN(1), .IDLE_BIT(1'b0))
        dut_p (.clk(clk), .rst(rst), .bus(bus_p));

    seq_frame_tx #(.DATA_W(8), .SYNC_W(4), .SYNC_PAT(4'b1011), .PARITY_EN(0), .IDLE_BIT(1'b0))
        dut_n (.clk(clk), .rst(rst), .bus(bus_n));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame as the spec defines it: sync, payload MSB-first, then even parity if enabled.
    task automatic push_frame(input logic [7:0] w, input bit pe, inout fbit_t q[$]);
        fbit_t f;
        logic [3:0] sp;
        sp = 4'b1011;
        for (int i = 3; i >= 0; i--) begin
            f.b = sp[i];
            f.s = (i == 3);
            q.push_back(f);
        end
        for (int i = 7; i >= 0; i--) begin
            f.b = w[i];
            f.s = 1'b0;
            q.push_back(f);
        end
        if (pe) begin
            f.b = ^w;
            f.s = 1'b0;
            q.push_back(f);
        end
    endtask

    // Queue holds the bit on dout now plus those still to come; ready when at most one remains.
    task automatic model_step();
        bit rp;
        bit rn;
        if (!rst) begin
            qp.delete();
            qn.delete();
        end else begin
            rp = (qp.size() <= 1);
            rn = (qn.size() <= 1);
            if (qp.size() > 0) void'(qp.pop_front());
            if (qn.size() > 0) void'(qn.pop_front());
            if (valid && rp) push_frame(din, 1'b1, qp);
            if (valid && rn) push_frame(din, 1'b0, qn);
        end
    endtask

    task automatic check_all();
        logic eb;
        logic es;
        logic ee;
        ee = (qp.size() != 0);
        eb = ee ? qp[0].b : 1'b0;
        es = ee ? qp[0].s : 1'b0;
        chk("p_dout",    64'(bus_p.dout),      64'(eb));
        chk("p_dout_en", 64'(bus_p.dout_en),   64'(ee));
        chk("p_sof",     64'(bus_p.sof),       64'(es));
        chk("p_busy",    64'(bus_p.busy),      64'(ee));
        chk("p_ready",   64'(bus_p.din_ready), 64'(rst && (qp.size() <= 1)));
        ee = (qn.size() != 0);
        eb = ee ? qn[0].b : 1'b0;
        es = ee ? qn[0].s : 1'b0;
        chk("n_dout",    64'(bus_n.dout),      64'(eb));
        chk("n_dout_en", 64'(bus_n.dout_en),   64'(ee));
        chk("n_sof",     64'(bus_n.sof),       64'(es));
        chk("n_busy",    64'(bus_n.busy),      64'(ee));
        chk("n_ready",   64'(bus_n.din_ready), 64'(rst && (qn.size() <= 1)));
        if (cap_on && bus_p.dout_en) begin
            cap_p = {cap_p[62:0], bus_p.dout};
            cap_p_n++;
        end
        if (cap_on && bus_n.dout_en) begin
            cap_n = {cap_n[62:0], bus_n.dout};
            cap_n_n++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic cap_start();
        cap_on  = 1'b1;
        cap_p   = '0;
        cap_n   = '0;
        cap_p_n = 0;
        cap_n_n = 0;
    endtask

    task automatic send_one(input logic [7:0] w, input int unsigned drain);
        valid = 1'b1;
        din   = w;
        tick();
        valid = 1'b0;
        for (int i = 0; i < int'(drain); i++) tick();
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        cap_on   = 1'b0;
        cap_p    = '0;
        cap_n    = '0;
        cap_p_n  = 0;
        cap_n_n  = 0;
        rst      = 1'b0;
        valid    = 1'b0;
        din      = 8'h00;

        // Reset and idle
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) tick();

        // Single frame, even parity
        cap_start();
        send_one(8'hA5, 16);
        chk("a5_p_frame", cap_p, 64'({4'b1011, 8'hA5, 1'b0}));
        chk("a5_p_len",   64'(cap_p_n), 64'd13);
        chk("a5_n_frame", cap_n, 64'({4'b1011, 8'hA5}));
        chk("a5_n_len",   64'(cap_n_n), 64'd12);

        // Odd payload, parity bit set
        cap_start();
        send_one(8'h07, 16);
        chk("07_p_frame", cap_p, 64'({4'b1011, 8'h07, 1'b1}));
        chk("07_p_len",   64'(cap_p_n), 64'd13);

        // Back-to-back under held valid
        cap_start();
        valid = 1'b1;
        din   = 8'hFF;
        tick();
        din = 8'h00;
        for (int i = 0; i < 13; i++) tick();
        valid = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        chk("b2b_p_frame", cap_p, 64'({4'b1011, 8'hFF, 1'b0, 4'b1011, 8'h00, 1'b0}));
        chk("b2b_p_len",   64'(cap_p_n), 64'd26);
        chk("b2b_n_frame", cap_n, 64'({4'b1011, 8'hFF, 4'b1011, 8'h00}));
        chk("b2b_n_len",   64'(cap_n_n), 64'd24);

        // Stall and hold: pending word changes before it is accepted
        cap_start();
        valid = 1'b1;
        din   = 8'h5A;
        tick();
        valid = 1'b0;
        for (int i = 0; i < 13; i++) begin
            if (i == 2) begin
                valid = 1'b1;
                din   = 8'h3C;
            end
            if (i == 6) din = 8'hC3;
            tick();
        end
        valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("hold_p_frame", cap_p, 64'({4'b1011, 8'h5A, 1'b0, 4'b1011, 8'hC3, 1'b0}));
        chk("hold_n_frame", cap_n, 64'({4'b1011, 8'h5A, 4'b1011, 8'hC3}));

        // Reset during payload bit 3
        send_one(8'h66, 6);
        #2;
        rst = 1'b0;
        #1;
        model_step();
        chk("mid_rst_p_dout",  64'(bus_p.dout),      64'd0);
        chk("mid_rst_p_en",    64'(bus_p.dout_en),   64'd0);
        chk("mid_rst_p_ready", 64'(bus_p.din_ready), 64'd0);
        chk("mid_rst_n_en",    64'(bus_n.dout_en),   64'd0);
        check_all();
        tick();
        tick();
        rst = 1'b1;
        tick();
        cap_start();
        valid = 1'b1;
        din   = 8'h81;
        tick();
        chk("post_rst_sof", 64'(bus_p.sof), 64'd1);
        valid = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        chk("post_rst_p_frame", cap_p, 64'({4'b1011, 8'h81, 1'b0}));
        chk("post_rst_p_len",   64'(cap_p_n), 64'd13);
        cap_on = 1'b0;

        // Randomized traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            valid = ($urandom_range(0, 3) != 0);
            din   = 8'($urandom);
            tick();
        end
        valid = 1'b0;
        for (int i = 0; i < 30; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
